serial_adder: RTL and testbench

Bit-serial adder built around the team's 1-bit full adder. It sits directly downstream of the FA cell. Each cycle it feeds one operand bit pair plus a registered carry into the FA, and captures the FA's sum/carry outputs. This gives a WIDTH-bit add with a start/busy/done handshake, using one FA instance instead of a ripple chain.

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with a start/busy/done handshake.
// Each RUN cycle feeds one operand bit pair plus the registered carry through
// a single 1-bit full adder cell, LSB first. The result is built in a shift
// register and published to sum/carry when DONE is entered.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow flag 'ovf'.

// 1-bit full adder cell
module serial_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             carry,
  output logic             ovf
`else
  output logic             carry
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res, w_res_nxt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_s, w_fa_c, w_last;

  serial_adder_fa u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_cy),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // Counter reaches WIDTH-1 on the final bit; it holds up to WIDTH so never wraps.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so the full result ends right-aligned.
  generate
    if (WIDTH == 1) begin : g_res1
      assign w_res_nxt = w_fa_s;
    end else begin : g_resn
      assign w_res_nxt = {w_fa_s, r_res[WIDTH-1:1]};
    end
  endgenerate

  assign sum   = r_sum;
  assign carry = r_carry;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; start outside IDLE is simply dropped
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shifting, carry flop, bit counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh <= a_in;
            r_b_sh <= b_in;
            r_cy   <= c_in;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cy   <= w_fa_c;
          r_res  <= w_res_nxt;
          r_cnt  <= r_cnt + CW'(1);
          // Publish on the same edge that enters DONE so sum is valid with done
          if (w_last) begin
            r_sum   <= w_res_nxt;
            r_carry <= w_fa_c;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last) r_ovf <= r_cy ^ w_fa_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random
// operations checked against an arithmetic reference (a + b + cin).
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         c_in;
  logic         busy, done, carry;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: last completed add (cleared by reset)
  logic [W-1:0] exp_sum_q   = '0;
  logic         exp_carry_q = 1'b0;
  logic         exp_ovf_q   = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .carry (carry),
    .ovf   (ovf)
`else
    .carry (carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One add from start pulse through the IDLE cycle after done. Optionally
  // hammers start (with junk operands) during RUN and DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit spam);
    logic [W:0] full;
    logic       eovf;
    int         lat, nb, nd;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    eovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    a_in = a; b_in = b; c_in = c; start = 1'b1;
    tick;
    start = 1'b0;
    lat = -1; nb = 0; nd = 0;
    for (int i = 0; i <= W; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (lat < 0) lat = i;
      end
      if (i < W) begin
        chk("sum_held", sum, exp_sum_q);
        chk("carry_held", carry, exp_carry_q);
      end else begin
        chk("sum", sum, full[W-1:0]);
        chk("carry", carry, full[W]);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, eovf);
`endif
      end
      a_in  = spam ? '1 : W'($urandom);
      b_in  = spam ? '1 : W'($urandom);
      c_in  = 1'($urandom);
      start = spam;
      tick;
    end
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("done_count", nd, 1);
    chk("done_latency", lat, W);
    chk("busy_cycles", nb, W);
    exp_sum_q   = full[W-1:0];
    exp_carry_q = full[W];
    exp_ovf_q   = eovf;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick;
    chk("idle_nostart", busy, 0);

    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h5A, 8'hA5, 1'b1, 1'b0);
    run_op(8'h5A, 8'hA5, 1'b0, 1'b0);
    run_op(8'h03, 8'h04, 1'b0, 1'b1);   // start ignored during RUN/DONE
    chk("lockout_sum", sum, 8'h07);
    run_op(8'h21, 8'h13, 1'b0, 1'b0);   // accepted right after lockout
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);

    // Reset in the 4th RUN cycle aborts the add
    a_in = 8'h10; b_in = 8'h20; c_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    tick;
    rst = 1'b0;
    exp_sum_q = '0; exp_carry_q = 1'b0; exp_ovf_q = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
      tick;
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0);
    chk("after_abort_sum", sum, 8'h02);

    // Random operations, back to back, occasionally with start spam
    for (int k = 0; k < 24; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
